// File: rtl/px_pkg.sv
// Shared constants for the P-X state-control sequencer: default widths,
// wait-counter width and the phase encoding.
package px_pkg;

  localparam int unsigned PX_GW  = 3;
  localparam int unsigned PX_LW  = 4;
  localparam int unsigned PX_WCW = 8;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_ST1  = 3'd1;
  localparam logic [2:0] PH_ST2  = 3'd2;
  localparam logic [2:0] PH_STEP = 3'd3;
  localparam logic [2:0] PH_WAIT = 3'd4;
  localparam logic [2:0] PH_GOT  = 3'd5;

endpackage

// File: rtl/px_grp_len.sv
// Phase-length reduction: for every active state bit, look up its timing group
// and take the longest STROB1 and STROB2 lengths across all of them.
module px_grp_len
  import px_pkg::*;
#(
  parameter int unsigned           NST     = 24,
  parameter int unsigned           NGRP    = 5,
  parameter int unsigned           GW      = PX_GW,
  parameter int unsigned           LW      = PX_LW,
  parameter logic [NST*GW-1:0]     GRP_MAP = '0,
  parameter logic [NGRP*LW-1:0]    ST1_LEN = {NGRP{LW'(1)}},
  parameter logic [NGRP*LW-1:0]    ST2_LEN = '0
) (
  input  logic [NST-1:0] state,
  output logic [LW-1:0]  len1,
  output logic [LW-1:0]  len2
);

  logic [GW-1:0] grp;
  logic [LW-1:0] v1;
  logic [LW-1:0] v2;

  // Max-reduction over active states; a zero STROB1 length still costs one cycle.
  always_comb begin
    len1 = LW'(1);
    len2 = '0;
    grp  = '0;
    v1   = '0;
    v2   = '0;
    for (int unsigned i = 0; i < NST; i++) begin
      if (state[i]) begin
        grp = GRP_MAP[i*GW +: GW];
        if (32'(grp) < NGRP) begin
          v1 = ST1_LEN[32'(grp)*LW +: LW];
          v2 = ST2_LEN[32'(grp)*LW +: LW];
          if (v1 > len1) len1 = v1;
          if (v2 > len2) len2 = v2;
        end
      end
    end
  end

endmodule

// File: rtl/px_seq.sv
// P-X state-control sequencer: one-hot state register stepped through
// STROB1/STROB2 phases, optional front-panel step and bus-grant wait, and a
// one-clock GOT that loads the next state vector.
module px_seq
  import px_pkg::*;
#(
  parameter int unsigned           NST       = 24,
  parameter int unsigned           NGRP      = 5,
  parameter int unsigned           GW        = PX_GW,
  parameter int unsigned           LW        = PX_LW,
  parameter logic [NST*GW-1:0]     GRP_MAP   = '0,
  parameter logic [NGRP*LW-1:0]    ST1_LEN   = {NGRP{LW'(1)}},
  parameter logic [NGRP*LW-1:0]    ST2_LEN   = '0,
  parameter logic [NST-1:0]        BUS_MASK  = '0,
  parameter logic [NST-1:0]        RST_STATE = NST'(1),
  parameter int unsigned           WAIT_MAX  = 255
) (
  input  logic           __clk,
  input  logic           clo_n,
  input  logic [NST-1:0] enter,
  input  logic [NST-1:0] set,
  input  logic           mode,
  input  logic           step,
  input  logic           strob_fp,
  input  logic           zw,
  input  logic           oken,
  output logic [NST-1:0] state,
  output logic           got,
  output logic           strob1,
  output logic           strob2,
  output logic           busy,
  output logic           alarm
);

  localparam logic [PX_WCW-1:0] WAIT_LAST = PX_WCW'(WAIT_MAX - 1);

  logic [NST-1:0]    state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [PX_WCW-1:0] wcnt_q, wcnt_d;
  logic              alarm_q, alarm_d;
  logic              step_q;
  logic              fp_q;

  logic [LW-1:0]     len1, len2;
  logic              step_rise;
  logic              bus_hit;
  logic [2:0]        post_strobe;

  // State only changes when a new ST1 starts, so the live reduction equals the
  // lengths that were in force at ST1 entry.
  px_grp_len #(
    .NST     (NST),
    .NGRP    (NGRP),
    .GW      (GW),
    .LW      (LW),
    .GRP_MAP (GRP_MAP),
    .ST1_LEN (ST1_LEN),
    .ST2_LEN (ST2_LEN)
  ) u_grp_len (
    .state (state_q),
    .len1  (len1),
    .len2  (len2)
  );

  assign step_rise   = step & ~step_q;
  assign bus_hit     = |(state_q & BUS_MASK);
  assign post_strobe = mode ? PH_STEP : (bus_hit ? PH_WAIT : PH_GOT);

  // Phase sequencing, state loading and set override.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q + LW'(1);
    wcnt_d  = wcnt_q + PX_WCW'(1);
    alarm_d = 1'b0;
    case (phase_q)
      PH_IDLE: ;
      PH_ST1: begin
        if (cnt_q == len1 - LW'(1)) phase_d = (len2 != '0) ? PH_ST2 : post_strobe;
      end
      PH_ST2: begin
        if (cnt_q == len2 - LW'(1)) phase_d = post_strobe;
      end
      PH_STEP: begin
        if (step_rise || !mode) phase_d = bus_hit ? PH_WAIT : PH_GOT;
      end
      PH_WAIT: begin
        if (zw && oken) begin
          phase_d = PH_GOT;
        end else if (wcnt_q == WAIT_LAST) begin
          phase_d = PH_GOT;
          alarm_d = 1'b1;
        end
      end
      PH_GOT: begin
        state_d = enter;
        phase_d = (enter != '0) ? PH_ST1 : PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
    // Set aborts whatever is running; during GOT it merges with enter.
    if (set != '0) begin
      state_d = state_d | set;
      phase_d = PH_ST1;
      alarm_d = 1'b0;
    end
    if ((phase_d != phase_q) || (set != '0)) begin
      cnt_d  = '0;
      wcnt_d = '0;
    end
  end

  // Sequencer registers.
  always_ff @(posedge __clk or negedge clo_n) begin
    if (!clo_n) begin
      state_q <= RST_STATE;
      phase_q <= PH_ST1;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      alarm_q <= 1'b0;
      step_q  <= 1'b0;
      fp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      alarm_q <= alarm_d;
      step_q  <= step;
      fp_q    <= strob_fp;
    end
  end

  assign state  = state_q;
  assign got    = (phase_q == PH_GOT);
  assign strob2 = (phase_q == PH_ST2);
  assign strob1 = (phase_q == PH_ST1) |
                  (fp_q & ((phase_q == PH_IDLE) | (phase_q == PH_STEP)));
  assign busy   = (phase_q != PH_IDLE);
  assign alarm  = alarm_q;

endmodule
